// File: rtl/yacht_pkg.sv
// Shared definitions for the yacht dice game: dice count, roll limit and
// the roll sequencer state encoding.
package yacht_pkg;

    localparam int unsigned NUM_DICE          = 5;
    localparam int unsigned MAX_ROLLS_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ANIM   = 2'd1,
        DONE   = 2'd2,
        LOCKED = 2'd3
    } roll_state_t;

    // Hold mask captured on an accepted roll; nothing can be held before the first roll.
    function automatic logic [NUM_DICE-1:0] accept_mask(
        input logic                first_roll,
        input logic [NUM_DICE-1:0] sw
    );
        logic [NUM_DICE-1:0] mask;
        if (first_roll) begin
            mask = {NUM_DICE{1'b0}};
        end else begin
            mask = sw;
        end
        return mask;
    endfunction

endpackage

// File: rtl/roll_sequencer_if.sv
// Roll sequencer bus: requests from the game FSM / switches towards the
// sequencer, roll pulses and status back towards the dice manager and display.
interface roll_sequencer_if;
    import yacht_pkg::*;

    logic                turn_start;
    logic                roll_req;
    logic [NUM_DICE-1:0] hold_sw;
    logic                roll_en;
    logic [NUM_DICE-1:0] hold_mask;
    logic                busy;
    logic                roll_done;
    logic [1:0]          rolls_left;
    logic                roll_reject;

    modport master (
        output turn_start, roll_req, hold_sw,
        input  roll_en, hold_mask, busy, roll_done, rolls_left, roll_reject
    );

    modport slave (
        input  turn_start, roll_req, hold_sw,
        output roll_en, hold_mask, busy, roll_done, rolls_left, roll_reject
    );

endinterface

// File: rtl/anim_tick_gen.sv
// Clearable animation divider: a strobe one cycle after clear (when enabled)
// and then every TICK_DIV cycles while enabled. Clearing while disabled is silent.
module anim_tick_gen #(
    parameter int unsigned TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic strobe
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d;

    // Next counter value and strobe; the counter stops at zero when idle.
    always_comb begin
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (clr) begin
            cnt_d    = {CW{1'b0}};
            strobe_d = en;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = {CW{1'b0}};
                strobe_d = 1'b1;
            end else begin
                cnt_d    = cnt_q + CW'(1);
                strobe_d = 1'b0;
            end
        end else begin
            cnt_d    = {CW{1'b0}};
            strobe_d = 1'b0;
        end
    end

    // Divider state and registered strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= {CW{1'b0}};
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/roll_sequencer.sv
// Per-turn roll controller: enforces the roll limit, latches the hold mask
// on accept and drives a spaced train of roll_en pulses for the tumble animation.
module roll_sequencer import yacht_pkg::*; #(
    parameter int unsigned TICK_DIV   = 2_500_000,
    parameter int unsigned ANIM_STEPS = 12,
    parameter int unsigned MAX_ROLLS  = MAX_ROLLS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    roll_sequencer_if.slave  bus
);

    localparam int unsigned      SW         = $clog2(ANIM_STEPS + 1);
    localparam logic [SW-1:0]    LAST_STEP  = SW'(ANIM_STEPS - 1);
    localparam logic [1:0]       ROLLS_FULL = 2'(MAX_ROLLS);

    roll_state_t         state_q, state_d;
    logic [NUM_DICE-1:0] hold_q, hold_d;
    logic [1:0]          rolls_q, rolls_d;
    logic [SW-1:0]       step_q, step_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                reject_q, reject_d;
    logic                tick_clr_s;
    logic                tick_en_s;
    logic                roll_en_s;

    anim_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tick_clr_s),
        .en      (tick_en_s),
        .strobe  (roll_en_s)
    );

    // Turn/roll state machine next-state; turn_start overrides everything.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        rolls_d    = rolls_q;
        step_d     = step_q;
        done_d     = 1'b0;
        reject_d   = 1'b0;
        tick_clr_s = 1'b0;
        if (bus.turn_start) begin
            state_d    = IDLE;
            rolls_d    = ROLLS_FULL;
            hold_d     = {NUM_DICE{1'b0}};
            step_d     = {SW{1'b0}};
            tick_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.roll_req) begin
                        state_d    = ANIM;
                        hold_d     = accept_mask(rolls_q == ROLLS_FULL, bus.hold_sw);
                        step_d     = {SW{1'b0}};
                        tick_clr_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ANIM: begin
                    reject_d = bus.roll_req;
                    if (roll_en_s) begin
                        step_d = step_q + SW'(1);
                        if (step_q == LAST_STEP) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            rolls_d = rolls_q - 2'd1;
                        end else begin
                            state_d = ANIM;
                        end
                    end else begin
                        step_d = step_q;
                    end
                end
                DONE: begin
                    reject_d = bus.roll_req;
                    if (rolls_q == 2'd0) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    reject_d = bus.roll_req;
                    state_d  = LOCKED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy_d    = (state_d == ANIM);
    assign tick_en_s = (state_d == ANIM);

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hold_q   <= {NUM_DICE{1'b0}};
            rolls_q  <= ROLLS_FULL;
            step_q   <= {SW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rolls_q  <= rolls_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            reject_q <= reject_d;
        end
    end

    assign bus.roll_en     = roll_en_s;
    assign bus.hold_mask   = hold_q;
    assign bus.busy        = busy_q;
    assign bus.roll_done   = done_q;
    assign bus.rolls_left  = rolls_q;
    assign bus.roll_reject = reject_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// Self-checking bench for roll_sequencer: hand-computed vector table for the
// first turn, directed corner sequences, then random traffic against a
// time-arithmetic reference model.
module tb_roll_sequencer;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam int MR = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    roll_sequencer_if bus ();

    roll_sequencer #(
        .TICK_DIV   (TD),
        .ANIM_STEPS (ST),
        .MAX_ROLLS  (MR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_en = 0;
    int cnt_done = 0;
    int cnt_rej = 0;

    // Reference model: an accepted roll at edge acc yields pulses at acc+k*TD
    // and completion at acc+1+(ST-1)*TD, all counted in post-reset edges.
    int         m_e;
    bit         acc_v;
    int         acc;
    int         done_at;
    int         m_rolls;
    logic [4:0] m_hold;
    bit         m_en, m_busy, m_done, m_rej;

    typedef struct {
        logic       ts;
        logic       rq;
        logic [4:0] sw;
        logic       en;
        logic       busy;
        logic       done;
        logic [1:0] rolls;
        logic [4:0] hold;
        logic       rej;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, m_e);
        end
    endtask

    task automatic model_reset();
        m_e = 0; acc_v = 1'b0; acc = 0; done_at = 0;
        m_rolls = MR; m_hold = 5'b00000;
        m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rej = 1'b0;
    endtask

    task automatic model_edge(input logic ts, input logic rq, input logic [4:0] sw);
        bit ph_busy, ph_done;
        m_e++;
        ph_busy = acc_v && (m_e - 1 >= acc) && (m_e - 1 < done_at);
        ph_done = acc_v && (m_e - 1 == done_at);
        m_rej = 1'b0;
        if (ts) begin
            m_rolls = MR; m_hold = 5'b00000; acc_v = 1'b0;
        end else if (rq) begin
            if (!ph_busy && !ph_done && m_rolls > 0) begin
                acc = m_e; done_at = m_e + 1 + (ST - 1) * TD; acc_v = 1'b1;
                m_hold = (m_rolls == MR) ? 5'b00000 : sw;
            end else begin
                m_rej = 1'b1;
            end
        end
        if (acc_v && m_e == done_at) m_rolls--;
        m_busy = acc_v && m_e >= acc && m_e < done_at;
        m_en   = m_busy && ((m_e - acc) % TD == 0);
        m_done = acc_v && m_e == done_at;
    endtask

    // One clock: drive inputs, advance model at the edge, compare at the falling edge.
    task automatic step(input logic ts, input logic rq, input logic [4:0] sw);
        bus.turn_start = ts; bus.roll_req = rq; bus.hold_sw = sw;
        @(posedge clk);
        model_edge(ts, rq, sw);
        @(negedge clk);
        bus.turn_start = 1'b0; bus.roll_req = 1'b0;
        cnt_en   += int'(bus.roll_en);
        cnt_done += int'(bus.roll_done);
        cnt_rej  += int'(bus.roll_reject);
        check("model_roll_en",   8'(bus.roll_en),     8'(m_en));
        check("model_busy",      8'(bus.busy),        8'(m_busy));
        check("model_roll_done", 8'(bus.roll_done),   8'(m_done));
        check("model_reject",    8'(bus.roll_reject), 8'(m_rej));
        check("model_rolls",     8'(bus.rolls_left),  8'(m_rolls));
        check("model_hold",      8'(bus.hold_mask),   8'(m_hold));
    endtask

    task automatic wait_done(input string name);
        int start;
        start = cnt_done;
        for (int k = 0; k < 60 && cnt_done == start; k++) step(1'b0, 1'b0, 5'b11111);
        check({"wait_", name}, 8'(cnt_done - start), 8'd1);
    endtask

    task automatic add_vec(input logic ts, input logic rq, input logic [4:0] sw,
                           input logic en, input logic busy, input logic done,
                           input logic [1:0] rolls, input logic [4:0] hold, input logic rej);
        vec_t v;
        v.ts = ts; v.rq = rq; v.sw = sw; v.en = en; v.busy = busy; v.done = done;
        v.rolls = rolls; v.hold = hold; v.rej = rej;
        tbl.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_roll_en"}, 8'(bus.roll_en),     8'd0);
        check({tag, "_busy"},    8'(bus.busy),        8'd0);
        check({tag, "_done"},    8'(bus.roll_done),   8'd0);
        check({tag, "_reject"},  8'(bus.roll_reject), 8'd0);
        check({tag, "_rolls"},   8'(bus.rolls_left),  8'(MR));
        check({tag, "_hold"},    8'(bus.hold_mask),   8'd0);
    endtask

    initial begin
        int e0, d0, j0;
        reset_n = 1'b0;
        bus.turn_start = 1'b0; bus.roll_req = 1'b0; bus.hold_sw = 5'b00000;
        model_reset();

        // First turn, cycle by cycle: first roll ignores switches, second roll
        // latches 10101 despite a mid-animation toggle and a refused request.
        //      ts    rq    sw        en    busy  done  rolls hold      rej
        add_vec(1'b0, 1'b1, 5'b10101, 1'b1, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b1, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b1, 1'b1, 1'b0, 2'd3, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b0, 1'b1, 2'd2, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b0, 5'b10101, 1'b0, 1'b0, 1'b0, 2'd2, 5'b00000, 1'b0);
        add_vec(1'b0, 1'b1, 5'b10101, 1'b1, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b0, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b0, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b0, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b1, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b1, 5'b01010, 1'b0, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b1);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b0, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b0, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b1, 1'b1, 1'b0, 2'd2, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b0, 1'b0, 1'b1, 2'd1, 5'b10101, 1'b0);
        add_vec(1'b0, 1'b0, 5'b01010, 1'b0, 1'b0, 1'b0, 2'd1, 5'b10101, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ts, tbl[i].rq, tbl[i].sw);
            check($sformatf("vec%0d_en", i),    8'(bus.roll_en),     8'(tbl[i].en));
            check($sformatf("vec%0d_busy", i),  8'(bus.busy),        8'(tbl[i].busy));
            check($sformatf("vec%0d_done", i),  8'(bus.roll_done),   8'(tbl[i].done));
            check($sformatf("vec%0d_rolls", i), 8'(bus.rolls_left),  8'(tbl[i].rolls));
            check($sformatf("vec%0d_hold", i),  8'(bus.hold_mask),   8'(tbl[i].hold));
            check($sformatf("vec%0d_rej", i),   8'(bus.roll_reject), 8'(tbl[i].rej));
        end
        check("turn1_en_total",   8'(cnt_en),   8'd6);
        check("turn1_done_total", 8'(cnt_done), 8'd2);
        check("turn1_rej_total",  8'(cnt_rej),  8'd1);

        // Third roll exhausts the turn; a fourth request is refused.
        step(1'b0, 1'b1, 5'b01010);
        check("roll3_hold", 8'(bus.hold_mask), 8'h0a);
        wait_done("roll3");
        check("roll3_rolls", 8'(bus.rolls_left), 8'd0);
        step(1'b0, 1'b0, 5'b00000);
        e0 = cnt_en;
        step(1'b0, 1'b1, 5'b11111);
        check("locked_reject", 8'(bus.roll_reject), 8'd1);
        repeat (8) step(1'b0, 1'b0, 5'b11111);
        check("locked_no_en", 8'(cnt_en - e0), 8'd0);
        check("locked_rolls", 8'(bus.rolls_left), 8'd0);

        // turn_start between the first and second pulse cancels the roll.
        step(1'b1, 1'b0, 5'b00000);
        check("ts_rolls", 8'(bus.rolls_left), 8'(MR));
        step(1'b0, 1'b1, 5'b11111);
        wait_done("ts_pre");
        step(1'b0, 1'b0, 5'b00000);
        step(1'b0, 1'b1, 5'b11011);
        check("ts_hold_latched", 8'(bus.hold_mask), 8'h1b);
        step(1'b0, 1'b0, 5'b00000);
        step(1'b0, 1'b0, 5'b00000);
        e0 = cnt_en; d0 = cnt_done;
        step(1'b1, 1'b0, 5'b00000);
        check("cancel_rolls", 8'(bus.rolls_left), 8'(MR));
        check("cancel_hold",  8'(bus.hold_mask),  8'd0);
        check("cancel_busy",  8'(bus.busy),       8'd0);
        check("cancel_en",    8'(bus.roll_en),    8'd0);
        repeat (15) step(1'b0, 1'b0, 5'b00000);
        check("cancel_no_en",   8'(cnt_en - e0),   8'd0);
        check("cancel_no_done", 8'(cnt_done - d0), 8'd0);

        // Simultaneous turn_start and roll_req with one roll left.
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 1'b1, 5'b00110);
            wait_done("ts_rq_setup");
            step(1'b0, 1'b0, 5'b00000);
        end
        check("ts_rq_setup_rolls", 8'(bus.rolls_left), 8'd1);
        e0 = cnt_en; j0 = cnt_rej;
        step(1'b1, 1'b1, 5'b11111);
        check("ts_rq_rolls", 8'(bus.rolls_left),  8'(MR));
        check("ts_rq_en",    8'(bus.roll_en),     8'd0);
        check("ts_rq_rej",   8'(bus.roll_reject), 8'd0);
        repeat (6) step(1'b0, 1'b0, 5'b00000);
        check("ts_rq_no_en",  8'(cnt_en - e0),  8'd0);
        check("ts_rq_no_rej", 8'(cnt_rej - j0), 8'd0);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 5) == 0), 5'($urandom));
        end

        // Asynchronous reset in the middle of an animation.
        step(1'b1, 1'b0, 5'b00000);
        step(1'b0, 1'b1, 5'b00000);
        check("pre_areset_en", 8'(bus.roll_en), 8'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("areset");
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("areset_held_en",   8'(bus.roll_en), 8'd0);
        check("areset_held_busy", 8'(bus.busy),    8'd0);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 4) == 0), 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/roll_sequencer.md
# roll_sequencer

Per-turn roll controller sitting between the debounced Roll button / hold switches and the dice manager. It enforces the three-rolls-per-turn limit and latches the hold mask at the moment a roll is accepted. It drives a multi-step tumble animation by issuing a train of spaced `roll_en` pulses, then reports completion and remaining rolls to the game FSM and display.

## Interface
Parameters:
- `TICK_DIV`, 2_500_000: clock cycles between successive animation `roll_en` pulses (≥2).
- `ANIM_STEPS`, 12: `roll_en` pulses per accepted roll (≥1).
- `MAX_ROLLS`, 3: rolls allowed per turn (1..3; `rolls_left` is 2 bits).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `turn_start`  in  1  one-cycle pulse from the FSM at the start of each player turn.
- `roll_req`  in  1  one-cycle debounced Roll button pulse.
- `hold_sw`  in  5  raw hold switches, bit i = die i+1.
- `roll_en`  out  1  one-cycle pulse per animation step, to the dice manager.
- `hold_mask`  out  5  latched hold mask, to the dice manager.
- `busy`  out  1  high while the animation runs.
- `roll_done`  out  1  one-cycle pulse; final dice values are valid.
- `rolls_left`  out  2  rolls remaining this turn.
- `roll_reject`  out  1  one-cycle pulse when `roll_req` is refused.

## Operation
- States:
  - IDLE: can roll.
  - ANIM: animating.
  - DONE: one cycle, completion.
  - LOCKED: `rolls_left == 0`.
- IDLE + `roll_req` → ANIM (accept). On accept:
  - `hold_mask` ← `hold_sw`, except forced to 5'b00000 when `rolls_left == MAX_ROLLS`, because nothing can be held before the first roll.
  - Step counter and tick counter cleared.
- ANIM: the `roll_en` pulse train is issued. After the `ANIM_STEPS`-th pulse → DONE.
- DONE: `roll_done` = 1 and `rolls_left` decrements, both in this cycle. Next state is LOCKED if the new `rolls_left == 0`, otherwise IDLE.
- LOCKED: stays until `turn_start`.
- `roll_req` in ANIM, DONE or LOCKED: dropped, `roll_reject` pulses next cycle. No state change.
- `turn_start`, any state, highest priority:
  - Next cycle: IDLE, `rolls_left` = `MAX_ROLLS`, `hold_mask` = 0, counters cleared.
  - Any remaining `roll_en` pulses are cancelled and no `roll_done` is produced.
  - A simultaneous `roll_req` is dropped silently, with no reject.
- `hold_mask` is constant throughout ANIM and between rolls. Switch changes have no effect until the next accept.
- `busy` = (state == ANIM).
- Counter widths: tick counter uses `$clog2(TICK_DIV)` bits, step counter uses `$clog2(ANIM_STEPS+1)` bits. Neither ever wraps; both are cleared on accept and on `turn_start`.

## Timing
- All outputs are registered. Reset values: `roll_en`, `busy`, `roll_done`, `roll_reject` = 0; `hold_mask` = 0; `rolls_left` = `MAX_ROLLS`; state = IDLE.
- Accept sampled at edge T:
  - At T+1: `busy` = 1, `hold_mask` updated, first `roll_en`.
  - Pulse k (k = 0..`ANIM_STEPS`−1) occurs at T+1+k·`TICK_DIV`.
- `roll_done` and the `rolls_left` decrement occur at T+2+(`ANIM_STEPS`−1)·`TICK_DIV`. `busy` is 0 in that same cycle.
- Earliest next accept: the cycle after DONE.
- `roll_reject` occurs 1 cycle after the refused `roll_req`.
- Asynchronous reset mid-ANIM: outputs return to reset values immediately, with no further pulses.

## Structure
- Shared package `yacht_pkg`:
  - `NUM_DICE` = 5.
  - `MAX_ROLLS_DEFAULT` = 3.
  - `roll_state_t` enum {IDLE, ANIM, DONE, LOCKED}.
- One sub-module, `anim_tick_gen`: a clearable `TICK_DIV` divider that emits a strobe on clear+1 and then every `TICK_DIV` cycles.
- At top level, `roll_sequencer` replaces the direct FSM `roll_trigger` → dice manager `roll_en` path. The switch-to-LED wiring is unchanged.

## Test plan
Bench parameters: `TICK_DIV`=4, `ANIM_STEPS`=3, `MAX_ROLLS`=3.
1. Reset, `hold_sw`=5'b10101, `roll_req` at edge 10 → `hold_mask` stays 00000; `roll_en` at 11, 15, 19; `roll_done` and `rolls_left` 3→2 at 20; `busy` high 11–19.
2. Second roll with `hold_sw`=10101, switches toggled to 01010 mid-animation → `hold_mask` = 10101 from accept+1 through `roll_done`; `rolls_left`=1.
3. Third roll → `rolls_left`=0, then LOCKED; a fourth `roll_req` → one `roll_reject` pulse, no `roll_en`, `rolls_left` stays 0.
4. `roll_req` at the second `roll_en` of an animation → `roll_reject` next cycle; exactly 3 `roll_en` pulses and 1 `roll_done` total.
5. `turn_start` between the first and second pulses → no further `roll_en`, no `roll_done`; next cycle `rolls_left`=3, `hold_mask`=0, `busy`=0.
6. `turn_start` and `roll_req` in the same cycle from IDLE with `rolls_left`=1 → `rolls_left`=3, no `roll_en`, no `roll_reject`.
